// File: rtl/filt5_decode.sv
// Five-line synchroniser + per-bit glitch filter feeding a registered Q0.Q1.Q2.~Q3.~Q4 decode.
// Define MATCH_COUNT_EN to build in the saturating match counter and its CNT port.
module filt5_bit #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic d,
    output logic q
);
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FILT_LEN - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic            q_q, q_d;
    logic [FC_W-1:0] fc_q, fc_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        q_d  = q_q;
        fc_d = fc_q;
        if (ce) begin
            // Any return to the current Q throws away the partial count.
            if (s2_q == q_q) begin
                fc_d = '0;
            end else if (fc_q == FC_MAX) begin
                q_d  = s2_q;
                fc_d = '0;
            end else begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            q_q  <= 1'b0;
            fc_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            q_q  <= q_d;
            fc_q <= fc_d;
        end
    end

    assign q = q_q;
endmodule

module filt5_decode #(
    parameter int FILT_LEN  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 C,
    input  logic                 R,
    input  logic                 CE,
    input  logic [4:0]           D,
    output logic [4:0]           Q,
    output logic                 O,
    output logic                 OP
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0] CNT
`endif
);
    if (FILT_LEN < 1 || FILT_LEN > 15 || CNT_WIDTH < 1) begin : g_bad_param
        $error("filt5_decode: FILT_LEN must be 1..15 and CNT_WIDTH >= 1");
    end

    filt5_bit #(.FILT_LEN(FILT_LEN)) u_bit [4:0] (
        .clk (C),
        .rst (R),
        .ce  (CE),
        .d   (D),
        .q   (Q)
    );

    logic dec;
    logic o_q, o_d;
    logic op_q, op_d;

    always_comb begin
        dec  = Q[0] & Q[1] & Q[2] & ~Q[3] & ~Q[4];
        o_d  = o_q;
        // Pulse is forced low while disabled so a frozen cycle cannot stretch it.
        op_d = 1'b0;
        if (CE) begin
            o_d  = dec;
            op_d = dec & ~o_q;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            o_q  <= 1'b0;
            op_q <= 1'b0;
        end else begin
            o_q  <= o_d;
            op_q <= op_d;
        end
    end

    assign O  = o_q;
    assign OP = op_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (CE && op_q && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge C) begin
        if (R) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign CNT = cnt_q;
`endif
endmodule
